// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounces raw keypad-scanner samples and collects
// accepted keys into a 4-digit shift buffer that feeds the display scan mux.
// Keys 0-9 enter digits, A clears, B deletes the newest digit, C-F are ignored.
module keypad_entry_ctrl #(
  parameter int          DEB_CYCLES = 4,     // consecutive samples to accept press/release (2..15)
  parameter logic [3:0]  BLANK      = 4'hF   // code rendered as a blank digit
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       pressed,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [2:0] count,
  output logic       key_valid,
  output logic [3:0] last_key,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  // Terminal value of both debounce counters
  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cand_reg, cand_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] rcnt_reg, rcnt_next;
  logic [3:0] digit_reg [4];
  logic [3:0] digit_next [4];
  logic [2:0] count_reg, count_next;
  logic       key_valid_reg, key_valid_next;
  logic       err_reg, err_next;
  logic [3:0] last_key_reg, last_key_next;

  // Buffer contents after a digit entry (shift left) or a backspace (shift right).
  // Index 0 is the leftmost, oldest position.
  logic [3:0] shl_val [4];
  logic [3:0] shr_val [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shift
      if (gi < 3) begin : g_shl_mid
        assign shl_val[gi] = digit_reg[gi+1];
      end else begin : g_shl_new
        assign shl_val[gi] = cand_reg;
      end
      if (gi == 0) begin : g_shr_blank
        assign shr_val[gi] = BLANK;
      end else begin : g_shr_mid
        assign shr_val[gi] = digit_reg[gi-1];
      end
    end
  endgenerate

  // Next-state and output logic: debounce press, apply accepted key, debounce release
  always_comb begin
    state_next     = state_reg;
    cand_next      = cand_reg;
    cnt_next       = cnt_reg;
    rcnt_next      = rcnt_reg;
    digit_next     = digit_reg;
    count_next     = count_reg;
    key_valid_next = 1'b0;
    err_next       = 1'b0;
    last_key_next  = last_key_reg;

    case (state_reg)
      IDLE: begin
        if (pressed) begin
          cand_next  = key;
          cnt_next   = 4'd1;
          state_next = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (!pressed || key != cand_reg) begin
          // Bounce or key change: drop the candidate without acting
          state_next = IDLE;
        end else if (cnt_reg < DEB_LAST) begin
          cnt_next = cnt_reg + 4'd1;
        end else begin
          // Stable for DEB_CYCLES samples: accept exactly once
          key_valid_next = 1'b1;
          last_key_next  = cand_reg;
          rcnt_next      = 4'd0;
          state_next     = WAIT_REL;
          if (cand_reg <= 4'd9) begin
            if (count_reg < 3'd4) begin
              digit_next = shl_val;
              count_next = count_reg + 3'd1;
            end else begin
              err_next = 1'b1;
            end
          end else if (cand_reg == 4'hA) begin
            for (int i = 0; i < 4; i++) digit_next[i] = BLANK;
            count_next = 3'd0;
          end else if (cand_reg == 4'hB) begin
            if (count_reg != 3'd0) begin
              digit_next = shr_val;
              count_next = count_reg - 3'd1;
            end else begin
              err_next = 1'b1;
            end
          end
        end
      end

      WAIT_REL: begin
        if (pressed) begin
          // Any held or bounced-down sample restarts the release count
          rcnt_next = 4'd0;
        end else if (rcnt_reg == DEB_LAST) begin
          rcnt_next  = 4'd0;
          state_next = IDLE;
        end else begin
          rcnt_next = rcnt_reg + 4'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cand_reg      <= 4'd0;
      cnt_reg       <= 4'd0;
      rcnt_reg      <= 4'd0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= BLANK;
      count_reg     <= 3'd0;
      key_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      last_key_reg  <= 4'd0;
    end else begin
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      rcnt_reg      <= rcnt_next;
      digit_reg     <= digit_next;
      count_reg     <= count_next;
      key_valid_reg <= key_valid_next;
      err_reg       <= err_next;
      last_key_reg  <= last_key_next;
    end
  end

  assign digit0    = digit_reg[0];
  assign digit1    = digit_reg[1];
  assign digit2    = digit_reg[2];
  assign digit3    = digit_reg[3];
  assign count     = count_reg;
  assign key_valid = key_valid_reg;
  assign last_key  = last_key_reg;
  assign err       = err_reg;

endmodule
